// File: rtl/hc_sr04_echo_gen_if.sv
// Trigger/echo link between a ranging controller (master) and the
// HC-SR04 emulator (slave).
`timescale 1ns/1ps

interface hc_sr04_echo_gen_if #(
    parameter int DST_SZ = 9
);
    logic              I_EN;
    logic [DST_SZ-1:0] I_DST;
    logic              I_TRIG;
    logic              O_ECHO;
    logic              O_BUSY;
    logic              O_TRIG_ERR;

    // Controller side: drives trigger and configuration, receives the echo.
    modport master (
        output I_EN, I_DST, I_TRIG,
        input  O_ECHO, O_BUSY, O_TRIG_ERR
    );

    // Emulator side.
    modport slave (
        input  I_EN, I_DST, I_TRIG,
        output O_ECHO, O_BUSY, O_TRIG_ERR
    );
endinterface

// File: rtl/hc_sr04_echo_gen.sv
// HC-SR04 ultrasonic sensor emulator: accepts a trigger pulse and, after the
// burst delay, returns an echo pulse whose width encodes a distance in cm.
`timescale 1ns/1ps

module hc_sr04_echo_gen #(
    parameter int MAX_RANGE  = 400,
    parameter int DST_SZ     = $clog2(MAX_RANGE),
    parameter int CLK_PER_CM = 2941,
    parameter int TRIG_MIN   = 500,
    parameter int BURST_DLY  = 10000,
    parameter int TIMEOUT_CM = 646,
    parameter int HOLDOFF    = 50000
) (
    input  logic                CLK,
    input  logic                RST,
    hc_sr04_echo_gen_if.slave   bus
);

    // Echo length in cm never exceeds the larger of the range and timeout.
    localparam int CM_MAX  = (MAX_RANGE > TIMEOUT_CM) ? MAX_RANGE : TIMEOUT_CM;
    localparam int CM_W    = $clog2(CM_MAX + 1);
    localparam int PRE_W   = $clog2(CLK_PER_CM + 1);
    // One counter serves trigger width, burst delay and holdoff.
    localparam int CNT_M1  = (TRIG_MIN > BURST_DLY) ? TRIG_MIN : BURST_DLY;
    localparam int CNT_MAX = (CNT_M1 > HOLDOFF) ? CNT_M1 : HOLDOFF;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] TRIG_MIN_C = CNT_W'(TRIG_MIN);
    localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(BURST_DLY - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLDOFF - 1);
    localparam logic [PRE_W-1:0] PRE_LAST   = PRE_W'(CLK_PER_CM - 1);
    localparam logic [CM_W-1:0]  TIMEOUT_C  = CM_W'(TIMEOUT_CM);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_TRIG_HI = 3'd1,
        S_BURST   = 3'd2,
        S_ECHO    = 3'd3,
        S_HOLDOFF = 3'd4
    } state_e;

    state_e            state_q,     state_d;
    logic [1:0]        sync_q,      sync_d;
    logic              trig_prev_q, trig_prev_d;
    logic [CNT_W-1:0]  cnt_q,       cnt_d;
    logic [PRE_W-1:0]  pre_q,       pre_d;
    logic [CM_W-1:0]   cm_q,        cm_d;
    logic [DST_SZ-1:0] dst_q,       dst_d;
    logic              echo_q,      echo_d;
    logic              trig_err_q,  trig_err_d;

    logic              trig_s;
    logic [CM_W-1:0]   echo_w;
    logic [CM_W-1:0]   echo_last;

    assign trig_s = sync_q[1];

    // Echo width in cm: the latched distance when in range, otherwise the
    // no-object timeout.
    always_comb begin
        echo_w = TIMEOUT_C;
        if (dst_q != '0 && int'(dst_q) <= MAX_RANGE) begin
            echo_w = CM_W'(dst_q);
        end
        echo_last = echo_w - 1'b1;
    end

    // Next-state logic for the trigger/burst/echo/holdoff sequence.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path can
        // leave it unassigned and infer a latch.
        state_d     = state_q;
        sync_d      = {sync_q[0], bus.I_TRIG};
        trig_prev_d = trig_s;
        cnt_d       = cnt_q;
        pre_d       = pre_q;
        cm_d        = cm_q;
        dst_d       = dst_q;
        echo_d      = echo_q;
        trig_err_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                echo_d = 1'b0;
                cnt_d  = '0;
                // Rising-edge qualified so a trigger held across holdoff
                // is not taken as a new one.
                if (bus.I_EN && trig_s && !trig_prev_q) begin
                    state_d = S_TRIG_HI;
                    cnt_d   = CNT_W'(1);
                end
            end

            S_TRIG_HI: begin
                if (trig_s) begin
                    if (cnt_q < TRIG_MIN_C) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else if (cnt_q >= TRIG_MIN_C) begin
                    dst_d   = bus.I_DST;
                    cnt_d   = '0;
                    state_d = S_BURST;
                end else begin
                    trig_err_d = 1'b1;
                    cnt_d      = '0;
                    state_d    = S_IDLE;
                end
            end

            S_BURST: begin
                if (cnt_q == BURST_LAST) begin
                    cnt_d   = '0;
                    pre_d   = '0;
                    cm_d    = '0;
                    echo_d  = 1'b1;
                    state_d = S_ECHO;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_ECHO: begin
                if (pre_q == PRE_LAST) begin
                    pre_d = '0;
                    if (cm_q == echo_last) begin
                        echo_d  = 1'b0;
                        cnt_d   = '0;
                        state_d = S_HOLDOFF;
                    end else begin
                        cm_d = cm_q + 1'b1;
                    end
                end else begin
                    pre_d = pre_q + 1'b1;
                end
            end

            S_HOLDOFF: begin
                if (cnt_q == HOLD_LAST) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                pre_d   = '0;
                cm_d    = '0;
                echo_d  = 1'b0;
            end
        endcase
    end

    // State, synchroniser and counter registers with asynchronous reset.
    always_ff @(posedge CLK or posedge RST) begin
        // NOTE: non-blocking assignments so every flop samples the values
        // from before this edge, independent of statement order.
        if (RST) begin
            state_q     <= S_IDLE;
            sync_q      <= '0;
            trig_prev_q <= 1'b0;
            cnt_q       <= '0;
            pre_q       <= '0;
            cm_q        <= '0;
            dst_q       <= '0;
            echo_q      <= 1'b0;
            trig_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync_q      <= sync_d;
            trig_prev_q <= trig_prev_d;
            cnt_q       <= cnt_d;
            pre_q       <= pre_d;
            cm_q        <= cm_d;
            dst_q       <= dst_d;
            echo_q      <= echo_d;
            trig_err_q  <= trig_err_d;
        end
    end

    assign bus.O_ECHO     = echo_q;
    assign bus.O_TRIG_ERR = trig_err_q;
    assign bus.O_BUSY     = (state_q != S_IDLE);

endmodule
